// File: rtl/pw_patgen_pkg.sv
// Shared definitions for the byte-stream pattern generator: state encoding,
// filler LFSR constants and the byte-index width helper.
package pw_patgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pw_lfsr8.sv
// 8-bit Fibonacci LFSR supplying filler bytes; reloads the seed on load and
// steps only when advance is high.
module pw_lfsr8
    import pw_patgen_pkg::*;
(
    input  logic       fe_clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] value,
    output logic [7:0] next_value
);

    assign next_value = {value[6:0], ^(value & LFSR_TAPS)};

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= LFSR_SEED;
        end else if (load) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/pw_pattern_generator.sv
// Drives a snapshotted byte pattern onto a valid/ready stream with repeats and
// inter-repetition gaps. Define PW_PATGEN_NOISE_EN to fill gaps with LFSR bytes.
//
// Handshake: a byte transfers on a rising edge where O_fe_data_valid and
// I_fe_ready are both high; while valid is high and ready low, data is held.
module pw_pattern_generator
    import pw_patgen_pkg::*;
#(
    parameter int pPATTERN_BYTES = 8
) (
    input  logic                        fe_clk,
    input  logic                        reset_n,
    input  logic                        I_start,
    input  logic                        I_abort,
    input  logic [pPATTERN_BYTES*8-1:0] I_pattern,
    input  logic [7:0]                  I_pattern_bytes,
    input  logic [7:0]                  I_repeat,
    input  logic [7:0]                  I_gap,
    input  logic                        I_fe_ready,
    output logic [7:0]                  O_fe_data,
    output logic                        O_fe_data_valid,
    output logic                        O_busy,
    output logic                        O_done,
    output logic [1:0]                  dbg_state
);

    localparam int IW = idx_width(pPATTERN_BYTES);
    localparam int PW = pPATTERN_BYTES * 8;

    state_t          state;
    logic [PW-1:0]   pat_q;
    logic [7:0]      len_q;
    logic [7:0]      rep_q;
    logic [7:0]      gap_q;
    logic [7:0]      gap_cnt;
    logic [8:0]      rep_cnt;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   next_idx;
    logic [7:0]      clamped_bytes;
    logic            last_byte;
    logic [7:0]      pat_bytes [pPATTERN_BYTES];

    assign dbg_state = state;
    assign next_idx  = idx + 1'b1;
    assign last_byte = (8'(idx) == len_q - 8'd1);

    always_comb begin
        clamped_bytes = I_pattern_bytes;
        if (I_pattern_bytes > 8'(pPATTERN_BYTES)) begin
            clamped_bytes = 8'(pPATTERN_BYTES);
        end
    end

    always_comb begin
        for (int i = 0; i < pPATTERN_BYTES; i++) begin
            pat_bytes[i] = pat_q[8*i +: 8];
        end
    end

`ifdef PW_PATGEN_NOISE_EN
    logic [7:0] filler_value;
    logic [7:0] filler_next;
    logic       filler_load;
    logic       filler_advance;

    assign filler_load    = (state == ST_IDLE) && I_start && !I_abort;
    assign filler_advance = (state == ST_GAP) && O_fe_data_valid && I_fe_ready && !I_abort;

    pw_lfsr8 u_lfsr (
        .fe_clk     (fe_clk),
        .reset_n    (reset_n),
        .load       (filler_load),
        .advance    (filler_advance),
        .value      (filler_value),
        .next_value (filler_next)
    );
`endif

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            pat_q           <= '0;
            len_q           <= '0;
            rep_q           <= '0;
            gap_q           <= '0;
            gap_cnt         <= '0;
            rep_cnt         <= '0;
            idx             <= '0;
            O_fe_data       <= '0;
            O_fe_data_valid <= 1'b0;
            O_busy          <= 1'b0;
            O_done          <= 1'b0;
        end else if (I_abort) begin
            state           <= ST_IDLE;
            O_fe_data       <= '0;
            O_fe_data_valid <= 1'b0;
            O_busy          <= 1'b0;
            O_done          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    O_fe_data       <= '0;
                    O_fe_data_valid <= 1'b0;
                    O_busy          <= 1'b0;
                    O_done          <= 1'b0;
                    if (I_start) begin
                        pat_q   <= I_pattern;
                        len_q   <= clamped_bytes;
                        rep_q   <= I_repeat;
                        gap_q   <= I_gap;
                        idx     <= '0;
                        rep_cnt <= '0;
                        gap_cnt <= '0;
                        O_busy  <= 1'b1;
                        if (clamped_bytes == 8'd0) begin
                            state  <= ST_DONE;
                            O_done <= 1'b1;
                        end else begin
                            state           <= ST_SEND;
                            O_fe_data_valid <= 1'b1;
                            O_fe_data       <= I_pattern[7:0];
                        end
                    end
                end

                ST_SEND: begin
                    if (I_fe_ready) begin
                        if (!last_byte) begin
                            idx       <= next_idx;
                            O_fe_data <= pat_bytes[next_idx];
                        end else if (rep_cnt == {1'b0, rep_q}) begin
                            state           <= ST_DONE;
                            O_fe_data_valid <= 1'b0;
                            O_done          <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + 9'd1;
                            idx     <= '0;
                            if (gap_q != 8'd0) begin
                                state   <= ST_GAP;
                                gap_cnt <= '0;
`ifdef PW_PATGEN_NOISE_EN
                                O_fe_data_valid <= 1'b1;
                                O_fe_data       <= filler_value;
`else
                                O_fe_data_valid <= 1'b0;
`endif
                            end else begin
                                O_fe_data <= pat_bytes[0];
                            end
                        end
                    end
                end

                ST_GAP: begin
`ifdef PW_PATGEN_NOISE_EN
                    // Gap length counts accepted filler bytes, not cycles.
                    if (I_fe_ready) begin
                        if (gap_cnt == gap_q - 8'd1) begin
                            state     <= ST_SEND;
                            O_fe_data <= pat_bytes[0];
                        end else begin
                            gap_cnt   <= gap_cnt + 8'd1;
                            O_fe_data <= filler_next;
                        end
                    end
`else
                    if (gap_cnt == gap_q - 8'd1) begin
                        state           <= ST_SEND;
                        O_fe_data_valid <= 1'b1;
                        O_fe_data       <= pat_bytes[0];
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
`endif
                end

                ST_DONE: begin
                    state           <= ST_IDLE;
                    O_fe_data       <= '0;
                    O_fe_data_valid <= 1'b0;
                    O_busy          <= 1'b0;
                    O_done          <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pw_pattern_generator.sv
// Self-checking bench for pw_pattern_generator: a stream-level model predicts
// every output cycle; directed cases pin the model with literal expectations.
module tb_pw_pattern_generator;

    localparam int PB = 8;
    localparam logic [1:0] K_BYTE = 2'd0;
    localparam logic [1:0] K_IDLE = 2'd1;
    localparam logic [1:0] K_FILL = 2'd2;

    logic          fe_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          I_start = 1'b0;
    logic          I_abort = 1'b0;
    logic [63:0]   I_pattern = '0;
    logic [7:0]    I_pattern_bytes = '0;
    logic [7:0]    I_repeat = '0;
    logic [7:0]    I_gap = '0;
    logic          I_fe_ready = 1'b1;
    logic [7:0]    O_fe_data;
    logic          O_fe_data_valid;
    logic          O_busy;
    logic          O_done;
    logic [1:0]    dbg_state;

    pw_pattern_generator #(.pPATTERN_BYTES(PB)) dut (
        .fe_clk          (fe_clk),
        .reset_n         (reset_n),
        .I_start         (I_start),
        .I_abort         (I_abort),
        .I_pattern       (I_pattern),
        .I_pattern_bytes (I_pattern_bytes),
        .I_repeat        (I_repeat),
        .I_gap           (I_gap),
        .I_fe_ready      (I_fe_ready),
        .O_fe_data       (O_fe_data),
        .O_fe_data_valid (O_fe_data_valid),
        .O_busy          (O_busy),
        .O_done          (O_done),
        .dbg_state       (dbg_state)
    );

    // clock / ready driver
    always #5 fe_clk = ~fe_clk;

    logic ready_fixed = 1'b1;
    logic rnd_ready = 1'b0;

    always @(posedge fe_clk) begin
        #2;
        I_fe_ready = rnd_ready ? ($urandom_range(0, 9) < 7) : ready_fixed;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int total = 0;
    int bad = 0;
    int md = 0;
    logic [9:0] exp_q[$];
    logic [7:0] acc_log[$];
    logic [7:0] fill_log[$];
    int idle_cnt = 0;
    int valid_cnt = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Expected output stream: one entry per byte to transfer or idle gap cycle.
    task automatic build(input logic [63:0] pat, input int bytes, input int rep, input int gap);
        int len;
        logic [7:0] lf;
        len = (bytes > PB) ? PB : bytes;
        lf = 8'hA5;
        exp_q.delete();
        if (len == 0) return;
        for (int r = 0; r <= rep; r++) begin
            for (int i = 0; i < len; i++) exp_q.push_back({K_BYTE, pat[8*i +: 8]});
            if (r < rep) begin
                for (int g = 0; g < gap; g++) begin
`ifdef PW_PATGEN_NOISE_EN
                    exp_q.push_back({K_FILL, lf});
                    lf = lfsr_next(lf);
`else
                    exp_q.push_back({K_IDLE, 8'h00});
`endif
                end
            end
        end
    endtask

    always @(negedge fe_clk) begin
        logic [9:0] item;
        if (O_fe_data_valid) valid_cnt++;
        if (!reset_n) begin
            md = 0;
            exp_q.delete();
        end else begin
            case (md)
                0: begin
                    chk("idle_valid", 32'(O_fe_data_valid), 32'd0);
                    chk("idle_busy", 32'(O_busy), 32'd0);
                    chk("idle_done", 32'(O_done), 32'd0);
                    chk("idle_data", 32'(O_fe_data), 32'd0);
                    if (I_start && !I_abort) begin
                        build(I_pattern, int'(I_pattern_bytes), int'(I_repeat), int'(I_gap));
                        md = (exp_q.size() == 0) ? 2 : 1;
                    end
                end
                1: begin
                    chk("run_busy", 32'(O_busy), 32'd1);
                    chk("run_done", 32'(O_done), 32'd0);
                    item = exp_q[0];
                    if (item[9:8] == K_IDLE) begin
                        chk("gap_valid", 32'(O_fe_data_valid), 32'd0);
                        idle_cnt++;
                        if (!I_abort) void'(exp_q.pop_front());
                    end else begin
                        chk("run_valid", 32'(O_fe_data_valid), 32'd1);
                        chk("run_data", 32'(O_fe_data), 32'(item[7:0]));
                        if (I_fe_ready && !I_abort) begin
                            if (item[9:8] == K_BYTE) acc_log.push_back(O_fe_data);
                            else fill_log.push_back(O_fe_data);
                            void'(exp_q.pop_front());
                        end
                    end
                    if (I_abort) begin
                        exp_q.delete();
                        md = 0;
                    end else if (exp_q.size() == 0) begin
                        md = 2;
                    end
                end
                default: begin
                    chk("done_pulse", 32'(O_done), 32'd1);
                    chk("done_busy", 32'(O_busy), 32'd1);
                    chk("done_valid", 32'(O_fe_data_valid), 32'd0);
                    done_cnt++;
                    md = 0;
                end
            endcase
        end
    end

    // driver tasks
    task automatic clear_stats();
        acc_log.delete();
        fill_log.delete();
        idle_cnt = 0;
        valid_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [63:0] pat, input logic [7:0] bytes,
                               input logic [7:0] rep, input logic [7:0] gap);
        I_pattern = pat;
        I_pattern_bytes = bytes;
        I_repeat = rep;
        I_gap = gap;
        I_start = 1'b1;
        @(posedge fe_clk);
        #1;
        I_start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((md != 0 || O_busy) && n < limit) begin
            @(posedge fe_clk);
            #1;
            n++;
        end
        if (n >= limit) begin
            total++;
            bad++;
            $display("FAIL wait_idle: still busy after %0d cycles", limit);
        end
        repeat (2) begin
            @(posedge fe_clk);
            #1;
        end
    endtask

    localparam logic [63:0] PAT = 64'h0807060504030201;

    initial begin
        bit seq [5];
        logic [7:0] exp_fill;

        // reset state
        #12;
        chk("rst_data", 32'(O_fe_data), 32'd0);
        chk("rst_valid", 32'(O_fe_data_valid), 32'd0);
        chk("rst_busy", 32'(O_busy), 32'd0);
        chk("rst_done", 32'(O_done), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        @(posedge fe_clk);
        #1;
        reset_n = 1'b1;
        @(posedge fe_clk);
        #1;

        // single send
        clear_stats();
        pulse_start(PAT, 8'd8, 8'd0, 8'd0);
        wait_idle(100);
        chk("single_count", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < acc_log.size(); i++)
            chk("single_byte", 32'(acc_log[i]), 32'(i + 1));
        chk("single_done", 32'(done_cnt), 32'd1);

        // backpressure
        clear_stats();
        seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        pulse_start(PAT, 8'd3, 8'd0, 8'd0);
        for (int k = 0; k < 5; k++) begin
            ready_fixed = seq[k];
            @(posedge fe_clk);
            #1;
        end
        ready_fixed = 1'b1;
        wait_idle(50);
        chk("bp_count", 32'(acc_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < acc_log.size(); i++)
            chk("bp_byte", 32'(acc_log[i]), 32'(i + 1));

        // repeat with gap
        clear_stats();
        pulse_start(PAT, 8'd2, 8'd2, 8'd3);
        wait_idle(100);
        chk("rg_count", 32'(acc_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < acc_log.size(); i++)
            chk("rg_byte", 32'(acc_log[i]), 32'((i % 2) + 1));
        chk("rg_done", 32'(done_cnt), 32'd1);
`ifdef PW_PATGEN_NOISE_EN
        chk("rg_fill_count", 32'(fill_log.size()), 32'd6);
`else
        chk("rg_idle_cycles", 32'(idle_cnt), 32'd6);
`endif

        // clamp and zero length
        clear_stats();
        pulse_start(PAT, 8'd20, 8'd0, 8'd0);
        wait_idle(100);
        chk("clamp_count", 32'(acc_log.size()), 32'd8);
        clear_stats();
        pulse_start(PAT, 8'd0, 8'd3, 8'd2);
        wait_idle(20);
        chk("zero_valid", 32'(valid_cnt), 32'd0);
        chk("zero_done", 32'(done_cnt), 32'd1);

        // abort during byte 4
        clear_stats();
        pulse_start(PAT, 8'd8, 8'd0, 8'd0);
        repeat (3) begin
            @(posedge fe_clk);
            #1;
        end
        I_abort = 1'b1;
        @(posedge fe_clk);
        #1;
        I_abort = 1'b0;
        chk("abort_valid", 32'(O_fe_data_valid), 32'd0);
        chk("abort_busy", 32'(O_busy), 32'd0);
        wait_idle(20);
        chk("abort_count", 32'(acc_log.size()), 32'd3);
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // start and abort together
        I_pattern_bytes = 8'd4;
        I_start = 1'b1;
        I_abort = 1'b1;
        @(posedge fe_clk);
        #1;
        I_start = 1'b0;
        I_abort = 1'b0;
        chk("sa_busy", 32'(O_busy), 32'd0);
        chk("sa_valid", 32'(O_fe_data_valid), 32'd0);

        // asynchronous reset mid-send
        pulse_start(PAT, 8'd8, 8'd3, 8'd1);
        repeat (3) begin
            @(posedge fe_clk);
            #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(O_fe_data_valid), 32'd0);
        chk("arst_busy", 32'(O_busy), 32'd0);
        chk("arst_data", 32'(O_fe_data), 32'd0);
        chk("arst_done", 32'(O_done), 32'd0);
        @(posedge fe_clk);
        #1;
        reset_n = 1'b1;
        wait_idle(20);

        // 256 repetitions from repeat=255
        clear_stats();
        pulse_start(64'h00000000000000C3, 8'd1, 8'd255, 8'd0);
        wait_idle(2000);
        chk("rep255_count", 32'(acc_log.size()), 32'd256);
        chk("rep255_done", 32'(done_cnt), 32'd1);

`ifdef PW_PATGEN_NOISE_EN
        // filler content with gap=2
        clear_stats();
        pulse_start(PAT, 8'd3, 8'd1, 8'd2);
        wait_idle(100);
        chk("noise_fill_count", 32'(fill_log.size()), 32'd2);
        exp_fill = 8'hA5;
        if (fill_log.size() > 0) chk("noise_fill0", 32'(fill_log[0]), 32'(exp_fill));
        exp_fill = 8'h4A;
        if (fill_log.size() > 1) chk("noise_fill1", 32'(fill_log[1]), 32'(exp_fill));
        chk("noise_resume", 32'(acc_log.size()), 32'd6);
        if (acc_log.size() > 3) chk("noise_byte0", 32'(acc_log[3]), 32'h01);
`else
        exp_fill = 8'h00;
`endif

        // randomized runs with backpressure, late register writes, stray starts, aborts
        rnd_ready = 1'b1;
        for (int run = 0; run < 40; run++) begin
            int cyc;
            int ab_at;
            pulse_start({$urandom, $urandom}, 8'($urandom_range(0, 12)),
                        8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
            cyc = $urandom_range(5, 40);
            ab_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, cyc - 1) : -1;
            for (int k = 0; k < cyc; k++) begin
                I_pattern = {$urandom, $urandom};
                I_pattern_bytes = 8'($urandom_range(0, 12));
                I_repeat = 8'($urandom_range(0, 3));
                I_gap = 8'($urandom_range(0, 3));
                I_start = ($urandom_range(0, 15) == 0);
                I_abort = (k == ab_at);
                @(posedge fe_clk);
                #1;
            end
            I_start = 1'b0;
            I_abort = 1'b0;
            wait_idle(600);
        end
        rnd_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pw_pattern_generator.md
# pw_pattern_generator

Byte-stream pattern generator that drives a programmed pattern onto a front-end-style data/valid stream, as the transmitting counterpart of the pattern matcher. Sits in the fe_clk domain between the register block and a mux in front of the matcher and capture block. Used for self-test and trigger characterisation without live USB traffic. Supports repetition, inter-pattern gaps and a valid/ready backpressure handshake.

## Interface
- pPATTERN_BYTES, 8, maximum pattern length in bytes; pattern and byte-index widths derive from it.
- fe_clk  input  1  sole clock; all logic is rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- I_start  input  1  one-cycle request to begin; sampled only in IDLE.
- I_abort  input  1  return to IDLE; takes priority over everything except reset.
- I_pattern  input  pPATTERN_BYTES*8  pattern; byte 0 is I_pattern[7:0] and is sent first.
- I_pattern_bytes  input  8  bytes per repetition; values above pPATTERN_BYTES clamp to pPATTERN_BYTES.
- I_repeat  input  8  repetitions minus one; 0 sends the pattern once.
- I_gap  input  8  gap length between repetitions; 0 means back-to-back.
- I_fe_ready  input  1  consumer accepts the current byte.
- O_fe_data  output  8  current byte.
- O_fe_data_valid  output  1  O_fe_data is valid.
- O_busy  output  1  high in any state other than IDLE.
- O_done  output  1  one-cycle pulse on normal completion.

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE: all outputs 0. On I_start:
  - snapshot I_pattern, the clamped I_pattern_bytes, I_repeat and I_gap;
  - clear the byte index and repetition counter.
  - Register writes made after start have no effect until the next start.
- IDLE with I_start and clamped length 0: go directly to DONE; no byte is emitted.
- SEND:
  - O_fe_data_valid=1; O_fe_data = snapshot byte at the current index.
  - A byte is accepted when valid and I_fe_ready are both high at a rising edge. Each accepted byte advances the index.
  - After the last byte of a repetition is accepted:
    - if repetitions remain and gap>0, go to GAP;
    - if repetitions remain and gap=0, stay in SEND with index 0;
    - if no repetitions remain, go to DONE.
- GAP (base build): valid=0. Counts I_gap cycles regardless of I_fe_ready, then returns to SEND with index 0.
- DONE: lasts one cycle; O_done=1, O_busy=1; then IDLE.
- I_abort in any state: next state IDLE; valid deasserts on the next edge; no O_done pulse.
- I_start outside IDLE is ignored.
- The repetition counter is 9 bits wide, so I_repeat=255 yields 256 transmissions with no wrap.

## Timing
- Reset values: O_fe_data=0, O_fe_data_valid=0, O_busy=0, O_done=0, state=IDLE.
- All outputs are registered.
- I_start high at edge N: O_busy and valid are high from edge N+1, carrying byte 0.
- Valid/ready handshake:
  - O_fe_data is held stable while valid=1 and ready=0.
  - With ready held high, one byte is accepted per cycle.
- Last byte of the final repetition accepted at edge M: O_done is high for the cycle after M; O_busy falls one cycle later.
- Gap with ready held high: exactly I_gap cycles with valid=0 between the last byte of one repetition and byte 0 of the next.
- I_start and I_abort in the same cycle: abort wins and the generator stays in IDLE.

## Configuration
- PW_PATGEN_NOISE_EN defined:
  - GAP emits filler bytes with valid=1 instead of idling.
  - Filler comes from an 8-bit Fibonacci LFSR with taps x^8+x^6+x^5+x^4+1.
  - The LFSR is seeded 0xA5 at reset and at every start, and advances only on an accepted filler byte.
  - The gap counter counts accepted filler bytes rather than cycles.
  - Filler may coincidentally equal pattern bytes; this is intended, because it exercises the matcher's restart behaviour.
- PW_PATGEN_NOISE_EN undefined: the LFSR is absent and GAP behaves as described under Operation.

## Structure
- Shared package pw_patgen_pkg holds:
  - the state encoding constants (IDLE, SEND, GAP, DONE);
  - the LFSR seed 0xA5 and tap mask;
  - the byte-index width function derived from pPATTERN_BYTES.
- One sub-module, pw_lfsr8: 8-bit LFSR with seed-load and advance-enable inputs. It is instantiated only under PW_PATGEN_NOISE_EN.

## Test plan
- Single send: pattern=0x0807060504030201, bytes=8, repeat=0, ready=1. Expect 01..08 on consecutive cycles, O_done one cycle after 08, then IDLE.
- Backpressure: bytes=3, ready toggles 1,0,0,1,1. Expect each byte held while ready=0, exactly 3 acceptances, and correct order.
- Repeat with gap: bytes=2, repeat=2, gap=3, ready=1. Expect 3×(01,02) with 3 idle cycles between repetitions; O_done after the 6th byte.
- Clamp and zero-length:
  - bytes=20 → exactly 8 bytes sent;
  - bytes=0 → O_done one cycle after start with valid never asserted.
- Abort and reset mid-run:
  - I_abort during byte 4 → valid low next cycle, no O_done;
  - reset_n low mid-SEND → outputs 0 immediately and asynchronously.
- Noise (PW_PATGEN_NOISE_EN): gap=2 → first gap emits 0xA5 followed by the LFSR successor; the pattern then resumes at byte 0.
